fetch_stage: RTL

//   Instruction-fetch stage of the 32-bit pipelined CPU. Owns the program counter and the IF/ID pipeline register.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/fetch_stage_if.sv | 24 ++
 rtl/fetch_stage_next_pc_sel.sv | 41 ++++
 rtl/fetch_stage.sv | 125 ++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types and constants: fetch FSM states, IF/ID bundle,
// reset/NOP defaults and the PC increment.
package cpu_pkg;

  typedef enum logic {
    IDLE,
    REQ
  } fetch_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } if_id_t;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF    = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory req/ack handshake between fetch stage and imem.
// Master drives req/addr; slave answers with ack/rdata.
interface fetch_stage_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_stage_next_pc_sel.sv
// Combinational next-PC mux: sequential PC+4 or a jump/branch
// redirect (jump wins), plus redirect and misaligned-target flags.
module next_pc_sel
  import cpu_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic        i_jump,
  input  logic [25:0] i_jump_index,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  input  logic [31:0] i_if_id_pc_plus4,
  input  logic        i_if_id_valid,
  output logic [31:0] o_next_pc,
  output logic        o_redirect,
  output logic        o_misaligned
);

  logic [31:0] w_target;
  logic        w_unused;

  // only the region bits of the IF/ID PC+4 feed a J-type target
  assign w_unused = ^i_if_id_pc_plus4[27:0];

  always_comb begin
    w_target = i_branch_target;
    if (i_jump) begin
      w_target = {i_if_id_pc_plus4[31:28],
                  i_jump_index, 2'b00};
    end
  end

  assign o_redirect =
    i_if_id_valid & (i_jump | i_branch_taken);

  assign o_next_pc =
    o_redirect ? w_target : i_pc + PC_INC;

  assign o_misaligned =
    o_redirect & (w_target[1:0] != 2'b00);

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, imem req/ack FSM and IF/ID register.
// Define DELAY_SLOT_EN to let a same-cycle fetch survive a redirect.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [31:0] NOP_INSTR    = NOP_INSTR_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          branch_taken,
  input  logic [31:0]   branch_target,
  input  logic          jump,
  input  logic [25:0]   jump_index,
  fetch_stage_if.master imem,
  output logic [31:0]   pc,
  output logic          if_id_valid,
  output logic [31:0]   if_id_instr,
  output logic [31:0]   if_id_pc_plus4,
  output logic          misalign_err
);

  localparam if_id_t BUBBLE = '{
    valid:    1'b0,
    instr:    NOP_INSTR,
    pc_plus4: 32'h0
  };

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  logic         w_req;

  logic [31:0]  r_pc;
  logic [31:0]  w_pc_d;
  if_id_t       r_ifid;
  if_id_t       w_ifid_d;
  if_id_t       w_fill;
  logic         r_err;

  logic [31:0]  w_next_pc;
  logic         w_redirect;
  logic         w_misaligned;
  logic         w_fire;

  next_pc_sel u_next_pc_sel (
    .i_pc             (r_pc),
    .i_jump           (jump),
    .i_jump_index     (jump_index),
    .i_branch_taken   (branch_taken),
    .i_branch_target  (branch_target),
    .i_if_id_pc_plus4 (r_ifid.pc_plus4),
    .i_if_id_valid    (r_ifid.valid),
    .o_next_pc        (w_next_pc),
    .o_redirect       (w_redirect),
    .o_misaligned     (w_misaligned)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    unique case (r_state)
      IDLE: w_state_nxt = REQ;
      REQ:  w_req       = 1'b1;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_fire = w_req & imem.imem_ack & ~stall;

  assign w_fill = '{
    valid:    1'b1,
    instr:    imem.imem_rdata,
    pc_plus4: r_pc + PC_INC
  };

  // a redirect beats both stall and an in-flight ack
  always_comb begin
    w_pc_d   = r_pc;
    w_ifid_d = r_ifid;
    priority case (1'b1)
      w_redirect: begin
        w_pc_d = w_next_pc;
`ifdef DELAY_SLOT_EN
        w_ifid_d = w_fire ? w_fill : BUBBLE;
`else
        w_ifid_d = BUBBLE;
`endif
      end
      w_fire: begin
        w_pc_d   = w_next_pc;
        w_ifid_d = w_fill;
      end
      !stall:  w_ifid_d = BUBBLE;
      default: w_ifid_d = r_ifid;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc   <= RESET_VECTOR;
      r_ifid <= BUBBLE;
      r_err  <= 1'b0;
    end else begin
      r_pc   <= w_pc_d;
      r_ifid <= w_ifid_d;
      r_err  <= r_err | w_misaligned;
    end
  end

  assign imem.imem_req  = w_req;
  assign imem.imem_addr = r_pc;

  assign pc             = r_pc;
  assign if_id_valid    = r_ifid.valid;
  assign if_id_instr    = r_ifid.instr;
  assign if_id_pc_plus4 = r_ifid.pc_plus4;
  assign misalign_err   = r_err;

endmodule
